dir_queue: RTL and testbench
============================

DIR_QUEUE -- requirements
Module: dir_queue

Interface
REQ-001 Parameter PLAYERS, default 1, number of independent direction channels; legal values 1..2.
REQ-002 Parameter DEPTH, default 4, entries per direction FIFO; power of two, 2..8.
REQ-003 One clock, clk, and reset rst, which SHALL be asynchronous and active-high.
REQ-004 clk  input  1  system clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 key  input  8  PS/2 set-2 make code from keyboard, E0 prefix already stripped.
REQ-007 key_pressed  input  1  one-cycle strobe, key valid.
REQ-008 step  input  1  one-cycle game tick.
REQ-009 dead  input  1  one-cycle strobe, collision detected.
REQ-010 snake_dir  output  2*PLAYERS  applied direction per player; player p occupies bits [2p+1:2p].
REQ-011 step_out  output  1  registered step, gated to RUN state.
REQ-012 state  output  2  game state: 0 IDLE, 1 RUN, 2 PAUSE, 3 DEAD.
REQ-013 overflow  output  PLAYERS  sticky flag per player, accepted-class key dropped because FIFO full.

Function
REQ-014 Direction encoding SHALL be 0 up, 1 right, 2 down, 3 left; opposite(d) = d+2 mod 4.
REQ-015 Key map: player 0 W=1D, D=23, S=1B, A=1C; player 1 arrows up=75, right=74, down=72, left=6B; Enter=5A start; Space=29 pause toggle; all other codes ignored.
REQ-016 With PLAYERS=1, arrow codes SHALL also map to player 0.
REQ-017 Transitions: IDLE-Enter->RUN; RUN-Space->PAUSE; PAUSE-Space->RUN; RUN or PAUSE -dead->DEAD; DEAD-Enter->RUN; all taking effect the cycle after the strobe.
REQ-018 dead SHALL take priority over a simultaneous Space key.
REQ-019 Entering RUN from IDLE or DEAD SHALL flush all FIFOs and set every snake_dir to right (1).
REQ-020 Direction keys SHALL be enqueued only in RUN; ignored in IDLE, PAUSE, DEAD.
REQ-021 Reference direction = last FIFO entry if non-empty, else current snake_dir; a key equal to or opposite of the reference SHALL be discarded without setting overflow.
REQ-022 An accepted key SHALL be visible as FIFO entry one cycle after key_pressed.
REQ-023 On step in RUN, step_out SHALL pulse the next cycle and, for each player with a non-empty FIFO, snake_dir SHALL take the head entry on that same edge and the head SHALL be popped.
REQ-024 On step outside RUN, step_out SHALL stay 0 and FIFOs/snake_dir SHALL be unchanged.
REQ-025 Simultaneous pop and push on a full FIFO: pop first, push accepted, no overflow.
REQ-026 Push on full FIFO without pop: entry dropped, overflow[p] set; cleared only by reset or entry to RUN from IDLE/DEAD.
REQ-027 FIFO read/write pointers SHALL be log2(DEPTH)+1 bits and wrap modulo 2*DEPTH; full when MSBs differ and low bits equal.

Reset
REQ-028 Asserting rst SHALL immediately force state IDLE, snake_dir all right (1), FIFOs empty, overflow 0, step_out 0, regardless of operation in progress.
REQ-029 First clk edge after rst deassertion SHALL process inputs normally.

Structure
REQ-030 Direction codes, state codes and scancode constants SHALL live in a shared include file used by game modules.
REQ-031 One sub-module dir_fifo (parameter DEPTH, 2-bit data, push/pop/full/empty/last outputs) SHALL be instantiated PLAYERS times via generate.

Verification
REQ-032 Reset, then Enter -> state 1 next cycle, snake_dir=1, overflow 0.
REQ-033 RUN, keys S then A, two steps -> snake_dir 2 after first step_out, 3 after second.
REQ-034 RUN, snake_dir=1, key A (opposite) then D (same) -> FIFO stays empty, snake_dir remains 1 after step.
REQ-035 DEPTH=4, RUN, five alternating valid keys no step -> overflow[0]=1, four steps yield exactly the first four directions.
REQ-036 RUN, Space, step -> state 2, step_out 0; Space again, step -> step_out pulse one cycle after step.
REQ-037 PLAYERS=2, W and up-arrow then dead, Enter -> state 3 then 1, both snake_dir 1, FIFOs empty; rst mid-sequence -> IDLE immediately.

Source files
------------

// File: rtl/dir_queue_pkg.sv
// Shared constants for the snake game input path: direction codes, game
// states, PS/2 set-2 make codes and the key decoder used by dir_queue.
package dir_queue_pkg;

   typedef enum logic [1:0] {
      DIR_UP    = 2'd0,
      DIR_RIGHT = 2'd1,
      DIR_DOWN  = 2'd2,
      DIR_LEFT  = 2'd3
   } dir_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DEAD  = 2'd3
   } state_t;

   localparam logic [7:0] SC_W     = 8'h1D;
   localparam logic [7:0] SC_D     = 8'h23;
   localparam logic [7:0] SC_S     = 8'h1B;
   localparam logic [7:0] SC_A     = 8'h1C;
   localparam logic [7:0] SC_UP    = 8'h75;
   localparam logic [7:0] SC_RIGHT = 8'h74;
   localparam logic [7:0] SC_DOWN  = 8'h72;
   localparam logic [7:0] SC_LEFT  = 8'h6B;
   localparam logic [7:0] SC_ENTER = 8'h5A;
   localparam logic [7:0] SC_SPACE = 8'h29;

   typedef struct packed {
      logic       valid;
      logic [1:0] dir;
   } key_dec_t;

   function automatic logic [1:0] opposite(input logic [1:0] d);
      return d + 2'd2;
   endfunction

   // wasd_en / arrow_en select which key groups steer the calling player.
   function automatic key_dec_t decode_key(input logic [7:0] code,
                                           input logic       wasd_en,
                                           input logic       arrow_en);
      key_dec_t d;
      d.valid = 1'b0;
      d.dir   = DIR_UP;
      if (wasd_en) begin
         case (code)
            SC_W:    begin d.valid = 1'b1; d.dir = DIR_UP;    end
            SC_D:    begin d.valid = 1'b1; d.dir = DIR_RIGHT; end
            SC_S:    begin d.valid = 1'b1; d.dir = DIR_DOWN;  end
            SC_A:    begin d.valid = 1'b1; d.dir = DIR_LEFT;  end
            default: ;
         endcase
      end
      if (arrow_en) begin
         case (code)
            SC_UP:    begin d.valid = 1'b1; d.dir = DIR_UP;    end
            SC_RIGHT: begin d.valid = 1'b1; d.dir = DIR_RIGHT; end
            SC_DOWN:  begin d.valid = 1'b1; d.dir = DIR_DOWN;  end
            SC_LEFT:  begin d.valid = 1'b1; d.dir = DIR_LEFT;  end
            default:  ;
         endcase
      end
      return d;
   endfunction

endpackage

// File: rtl/dir_queue_fifo.sv
// Small direction FIFO: 2-bit entries, extra pointer MSB distinguishes full
// from empty, exposes both head and most recently written entry.
module dir_fifo #(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       flush,
   input  logic       push,
   input  logic       pop,
   input  logic [1:0] din,
   output logic [1:0] head,
   output logic [1:0] last,
   output logic       full,
   output logic       empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic [AW:0] wr_prev;
   logic [1:0]  mem [DEPTH];
   logic        do_pop;
   logic        do_push;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   // A pop in the same cycle frees the slot the push needs.
   assign do_push = push && (!full || do_pop);
   assign wr_prev = wr_ptr - PTR_ONE;
   assign head    = mem[rd_ptr[AW-1:0]];
   assign last    = mem[wr_prev[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/dir_queue.sv
// Keyboard-driven game control: start/pause/dead state machine plus a
// per-player queue of pending turns applied one per game tick.
//
//   state    | meaning
//   ---------+-------------------------------------------------
//   ST_IDLE  | power-up, waiting for Enter
//   ST_RUN   | game running, turns queued, ticks forwarded
//   ST_PAUSE | frozen, only Space (resume) or dead accepted
//   ST_DEAD  | collision seen, waiting for Enter to restart
module dir_queue
   import dir_queue_pkg::*;
#(
   parameter int PLAYERS = 1,
   parameter int DEPTH   = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [7:0]             key,
   input  logic                   key_pressed,
   input  logic                   step,
   input  logic                   dead,
   output logic [2*PLAYERS-1:0]   snake_dir,
   output logic                   step_out,
   output logic [1:0]             state,
   output logic [PLAYERS-1:0]     overflow
);

   state_t state_q;
   state_t state_nxt;
   logic   flush;
   logic   step_run;
   logic   dir_en;
   logic   is_enter;
   logic   is_space;

   assign is_enter = key_pressed && (key == SC_ENTER);
   assign is_space = key_pressed && (key == SC_SPACE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_nxt;
   end

   always_comb begin
      state_nxt = state_q;
      flush     = 1'b0;
      step_run  = 1'b0;
      dir_en    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (is_enter) begin
               state_nxt = ST_RUN;
               flush     = 1'b1;
            end
         end
         ST_RUN: begin
            step_run = step;
            dir_en   = key_pressed;
            if (dead)          state_nxt = ST_DEAD;
            else if (is_space) state_nxt = ST_PAUSE;
         end
         ST_PAUSE: begin
            if (dead)          state_nxt = ST_DEAD;
            else if (is_space) state_nxt = ST_RUN;
         end
         ST_DEAD: begin
            if (is_enter) begin
               state_nxt = ST_RUN;
               flush     = 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) step_out <= 1'b0;
      else     step_out <= step_run;
   end

   assign state = state_q;

   for (genvar p = 0; p < PLAYERS; p++) begin : g_player
      key_dec_t   dec;
      logic [1:0] ref_dir;
      logic [1:0] head;
      logic [1:0] last;
      logic [1:0] dir_q;
      logic       full;
      logic       empty;
      logic       accept;
      logic       ovf_q;

      // With a single player the arrow keys also steer player 0.
      assign dec     = decode_key(key, (p == 0), (p == 1) || (PLAYERS == 1));
      assign ref_dir = empty ? dir_q : last;
      assign accept  = dir_en && dec.valid &&
                       (dec.dir != ref_dir) && (dec.dir != opposite(ref_dir));

      dir_fifo #(.DEPTH(DEPTH)) u_fifo (
         .clk   (clk),
         .rst   (rst),
         .flush (flush),
         .push  (accept),
         .pop   (step_run),
         .din   (dec.dir),
         .head  (head),
         .last  (last),
         .full  (full),
         .empty (empty)
      );

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            dir_q <= DIR_RIGHT;
            ovf_q <= 1'b0;
         end else if (flush) begin
            dir_q <= DIR_RIGHT;
            ovf_q <= 1'b0;
         end else begin
            if (step_run && !empty) dir_q <= head;
            if (accept && full && !step_run) ovf_q <= 1'b1;
         end
      end

      assign snake_dir[2*p+1:2*p] = dir_q;
      assign overflow[p]          = ovf_q;
   end

endmodule

// File: tb/tb_dir_queue.sv
// Directed bench for dir_queue: one single-player and one two-player
// instance share the same stimulus and are checked against hand values.
module tb_dir_queue;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] key;
   logic       key_pressed;
   logic       step;
   logic       dead;

   logic [1:0] dira;
   logic       stepa;
   logic [1:0] sta;
   logic [0:0] ovfa;

   logic [3:0] dirb;
   logic       stepb;
   logic [1:0] stb;
   logic [1:0] ovfb;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   dir_queue #(.PLAYERS(1), .DEPTH(4)) dut_a (
      .clk(clk), .rst(rst), .key(key), .key_pressed(key_pressed),
      .step(step), .dead(dead), .snake_dir(dira), .step_out(stepa),
      .state(sta), .overflow(ovfa)
   );

   dir_queue #(.PLAYERS(2), .DEPTH(4)) dut_b (
      .clk(clk), .rst(rst), .key(key), .key_pressed(key_pressed),
      .step(step), .dead(dead), .snake_dir(dirb), .step_out(stepb),
      .state(stb), .overflow(ovfb)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [7:0] c);
      key         = c;
      key_pressed = 1'b1;
      cyc();
      key_pressed = 1'b0;
   endtask

   task automatic do_step();
      step = 1'b1;
      cyc();
      step = 1'b0;
   endtask

   task automatic drain_chk(input string tag, input logic [1:0] exp_a, input logic [3:0] exp_b);
      do_step();
      chk({tag, "_stepa"}, 32'(stepa), 32'd1);
      chk({tag, "_dira"},  32'(dira),  32'(exp_a));
      chk({tag, "_dirb"},  32'(dirb),  32'(exp_b));
   endtask

   initial begin
      rst = 1'b1; key = 8'h00; key_pressed = 1'b0; step = 1'b0; dead = 1'b0;
      repeat (2) cyc();
      chk("rst_state",    32'(sta),   32'd0);
      chk("rst_dira",     32'(dira),  32'd1);
      chk("rst_dirb",     32'(dirb),  32'h5);
      chk("rst_ovfb",     32'(ovfb),  32'd0);
      chk("rst_step_out", 32'(stepa), 32'd0);
      rst = 1'b0;
      cyc();

      // start
      press(8'h5A);
      chk("start_state", 32'(sta),  32'd1);
      chk("start_stb",   32'(stb),  32'd1);
      chk("start_dira",  32'(dira), 32'd1);
      chk("start_ovfa",  32'(ovfa), 32'd0);

      // S then A, two steps
      press(8'h1B);
      press(8'h1C);
      drain_chk("sa1", 2'd2, 4'h6);
      cyc();
      chk("sa_pulse_one_cycle", 32'(stepa), 32'd0);
      drain_chk("sa2", 2'd3, 4'h7);

      // opposite then same are discarded
      press(8'h23);
      press(8'h1C);
      drain_chk("opp_same", 2'd3, 4'h7);
      chk("opp_same_ovf", 32'(ovfa), 32'd0);

      // fill, then push and pop together while full
      press(8'h1D); press(8'h1C); press(8'h1D); press(8'h1C);
      chk("fill4_ovf", 32'(ovfa), 32'd0);
      key = 8'h1D; key_pressed = 1'b1; step = 1'b1;
      cyc();
      key_pressed = 1'b0; step = 1'b0;
      chk("pushpop_dira", 32'(dira), 32'd0);
      chk("pushpop_ovfa", 32'(ovfa), 32'd0);
      chk("pushpop_ovfb", 32'(ovfb), 32'd0);
      drain_chk("pp_d1", 2'd3, 4'h7);
      drain_chk("pp_d2", 2'd0, 4'h4);
      drain_chk("pp_d3", 2'd3, 4'h7);
      drain_chk("pp_d4", 2'd0, 4'h4);

      // five alternating keys into depth 4 without a step
      press(8'h23); press(8'h1D); press(8'h23); press(8'h1D);
      chk("ovf_before_5th", 32'(ovfa), 32'd0);
      press(8'h23);
      chk("ovf_after_5th_a", 32'(ovfa), 32'd1);
      chk("ovf_after_5th_b", 32'(ovfb), 32'd1);
      drain_chk("ov_d1", 2'd1, 4'h5);
      drain_chk("ov_d2", 2'd0, 4'h4);
      drain_chk("ov_d3", 2'd1, 4'h5);
      drain_chk("ov_d4", 2'd0, 4'h4);
      drain_chk("ov_d5_empty", 2'd0, 4'h4);
      chk("ovf_sticky", 32'(ovfa), 32'd1);

      // pause
      press(8'h29);
      chk("pause_state", 32'(sta), 32'd2);
      do_step();
      chk("pause_step_out", 32'(stepa), 32'd0);
      chk("pause_dira",     32'(dira),  32'd0);
      press(8'h23);
      press(8'h29);
      chk("resume_state", 32'(sta), 32'd1);
      drain_chk("resume_step", 2'd0, 4'h4);

      // arrows: player 0 when single, player 1 when two
      press(8'h75);
      press(8'h6B);
      drain_chk("arrow1", 2'd3, 4'h0);
      drain_chk("arrow2", 2'd3, 4'hC);

      // queue entries, then dead wins over Space, then restart
      press(8'h23);
      press(8'h75);
      key = 8'h29; key_pressed = 1'b1; dead = 1'b1;
      cyc();
      key_pressed = 1'b0; dead = 1'b0;
      chk("dead_state_a", 32'(sta), 32'd3);
      chk("dead_state_b", 32'(stb), 32'd3);
      do_step();
      chk("dead_step_out", 32'(stepa), 32'd0);
      chk("dead_dirb",     32'(dirb),  32'hC);
      press(8'h5A);
      chk("restart_state", 32'(sta),  32'd1);
      chk("restart_dira",  32'(dira), 32'd1);
      chk("restart_dirb",  32'(dirb), 32'h5);
      chk("restart_ovfa",  32'(ovfa), 32'd0);
      chk("restart_ovfb",  32'(ovfb), 32'd0);
      drain_chk("restart_flushed", 2'd1, 4'h5);
      press(8'h5A);
      chk("enter_in_run", 32'(sta), 32'd1);

      // reset in the middle of a tick
      press(8'h1D);
      drain_chk("pre_rst", 2'd0, 4'h4);
      rst = 1'b1;
      #2;
      chk("midrst_state",    32'(sta),   32'd0);
      chk("midrst_step_out", 32'(stepa), 32'd0);
      chk("midrst_dira",     32'(dira),  32'd1);
      chk("midrst_dirb",     32'(dirb),  32'h5);
      repeat (2) cyc();
      rst = 1'b0;
      press(8'h5A);
      chk("post_rst_first_edge", 32'(sta), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
